// File: rtl/instr_cache.sv
// instr_cache: direct-mapped read-only instruction cache with a
// two-state block refill FSM and saturating hit/miss counters.
module instr_cache #(
   parameter int ADDR_W      = 10,
   parameter int NUM_BLOCKS  = 8,
   parameter int BLOCK_WORDS = 4,
   parameter int CNT_W       = 16
) (
   input  logic                                   CLK,
   input  logic                                   RESET,
   input  logic [31:0]                            PC,
   input  logic                                   READ,
   output logic [31:0]                            INSTRUCTION,
   output logic                                   BUSYWAIT,
   output logic                                   MEM_READ,
   output logic [ADDR_W-3-$clog2(BLOCK_WORDS):0]  MEM_ADDRESS,
   input  logic [32*BLOCK_WORDS-1:0]              MEM_READDATA,
   input  logic                                   MEM_BUSYWAIT,
   output logic [CNT_W-1:0]                       HIT_COUNT,
   output logic [CNT_W-1:0]                       MISS_COUNT
);

   localparam int WO_W  = $clog2(BLOCK_WORDS);
   localparam int IX_W  = $clog2(NUM_BLOCKS);
   localparam int BA_W  = ADDR_W - 2 - WO_W;
   localparam int TAG_W = BA_W - IX_W;
   localparam int OW    = (WO_W > 0) ? WO_W : 1;

   typedef enum logic {IDLE, MISS} state_e;

   state_e                       state_q, state_d;
   logic [NUM_BLOCKS-1:0]        valid_q;
   logic [TAG_W-1:0]             tag_q  [NUM_BLOCKS];
   logic [BLOCK_WORDS-1:0][31:0] data_q [NUM_BLOCKS];
   logic [BA_W-1:0]              miss_blk_q, miss_blk_d;
   logic [CNT_W-1:0]             hit_cnt_q, hit_cnt_d;
   logic [CNT_W-1:0]             miss_cnt_q, miss_cnt_d;

   logic [BA_W-1:0]  pc_blk;
   logic [IX_W-1:0]  pc_idx;
   logic [TAG_W-1:0] pc_tag;
   logic [OW-1:0]    pc_off;
   logic [IX_W-1:0]  miss_idx;
   logic             hit;
   logic             refill;
   logic             busy_raw;
   logic             mem_read_raw;
   logic             unused_pc;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign pc_blk   = PC[ADDR_W-1 -: BA_W];
   assign pc_idx   = pc_blk[IX_W-1:0];
   assign pc_tag   = pc_blk[BA_W-1 -: TAG_W];
   assign miss_idx = miss_blk_q[IX_W-1:0];

   generate
      if (WO_W > 0) begin : g_off
         assign pc_off = PC[2 +: OW];
      end else begin : g_no_off
         assign pc_off = '0;
      end
   endgenerate

   assign unused_pc = ^{PC[31:ADDR_W], PC[1:0]};

   assign hit = (state_q == IDLE) && READ && valid_q[pc_idx]
                && (tag_q[pc_idx] == pc_tag);

   assign INSTRUCTION = hit ? data_q[pc_idx][pc_off] : 32'h0;

   // Reset must silence the stall lines even while READ is held high.
   assign BUSYWAIT   = busy_raw & ~RESET;
   assign MEM_READ   = mem_read_raw & ~RESET;
   assign HIT_COUNT  = hit_cnt_q;
   assign MISS_COUNT = miss_cnt_q;

   always_comb begin
      state_d      = state_q;
      miss_blk_d   = miss_blk_q;
      hit_cnt_d    = hit_cnt_q;
      miss_cnt_d   = miss_cnt_q;
      refill       = 1'b0;
      busy_raw     = 1'b0;
      mem_read_raw = 1'b0;
      MEM_ADDRESS  = pc_blk;
      unique case (state_q)
         IDLE: begin
            if (hit) begin
               hit_cnt_d = sat_inc(hit_cnt_q);
            end else if (READ) begin
               busy_raw   = 1'b1;
               miss_blk_d = pc_blk;
               miss_cnt_d = sat_inc(miss_cnt_q);
               state_d    = MISS;
            end
         end
         MISS: begin
            busy_raw     = 1'b1;
            mem_read_raw = 1'b1;
            MEM_ADDRESS  = miss_blk_q;
            if (!MEM_BUSYWAIT) begin
               refill  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q    <= IDLE;
         valid_q    <= '0;
         miss_blk_q <= '0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         miss_blk_q <= miss_blk_d;
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
         if (refill) valid_q[miss_idx] <= 1'b1;
      end
   end

   // Tag and data arrays need no reset: valid bits gate their use.
   always_ff @(posedge CLK) begin
      if (refill) begin
         tag_q[miss_idx]  <= miss_blk_q[BA_W-1 -: TAG_W];
         data_q[miss_idx] <= MEM_READDATA;
      end
   end

endmodule

// File: tb/tb_instr_cache.sv
// tb_instr_cache: directed checks of the instruction cache against a
// block memory that stays busy 5 cycles then returns data for 1 cycle.
module tb_instr_cache;

   logic         CLK = 1'b0;
   logic         RESET;
   logic [31:0]  PC;
   logic         READ;
   logic [127:0] MEM_READDATA;
   logic         MEM_BUSYWAIT;

   logic [31:0]  instr, s_instr;
   logic         busy, s_busy;
   logic         mem_read, s_mem_read;
   logic [5:0]   mem_addr, s_mem_addr;
   logic [15:0]  hit_cnt, miss_cnt;
   logic [3:0]   s_hit_cnt, s_miss_cnt;

   int nvec = 0;
   int nerr = 0;
   int mcnt;

   always #5 CLK = ~CLK;

   instr_cache #(.ADDR_W(10), .NUM_BLOCKS(8), .BLOCK_WORDS(4), .CNT_W(16)) u_dut (
      .CLK(CLK), .RESET(RESET), .PC(PC), .READ(READ),
      .INSTRUCTION(instr), .BUSYWAIT(busy), .MEM_READ(mem_read),
      .MEM_ADDRESS(mem_addr), .MEM_READDATA(MEM_READDATA),
      .MEM_BUSYWAIT(MEM_BUSYWAIT), .HIT_COUNT(hit_cnt), .MISS_COUNT(miss_cnt)
   );

   instr_cache #(.ADDR_W(10), .NUM_BLOCKS(8), .BLOCK_WORDS(4), .CNT_W(4)) u_sat (
      .CLK(CLK), .RESET(RESET), .PC(PC), .READ(READ),
      .INSTRUCTION(s_instr), .BUSYWAIT(s_busy), .MEM_READ(s_mem_read),
      .MEM_ADDRESS(s_mem_addr), .MEM_READDATA(MEM_READDATA),
      .MEM_BUSYWAIT(MEM_BUSYWAIT), .HIT_COUNT(s_hit_cnt), .MISS_COUNT(s_miss_cnt)
   );

   // Memory word = 0x1000_0000 + byte address of that word.
   always_comb begin
      MEM_READDATA = '0;
      for (int k = 0; k < 4; k++)
         MEM_READDATA[32*k +: 32] = 32'h1000_0000 + (32'(mem_addr) << 4) + 32'(k * 4);
   end

   assign MEM_BUSYWAIT = !(mem_read && mcnt == 5);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)                   mcnt <= 0;
      else if (!mem_read || mcnt == 5) mcnt <= 0;
      else                         mcnt <= mcnt + 1;
   end

   task automatic cyc();
      @(posedge CLK);
      #2;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      do begin
         cyc();
         n++;
      end while (busy !== 1'b0 && n < 40);
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      READ  = 1'b0;
      PC    = 32'h0;
      cyc();
      cyc();
      RESET = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rst_busy got %b want 0", busy); end
      nvec++; if (mem_read !== 1'b0) begin nerr++; $display("FAIL rst_memread got %b want 0", mem_read); end
      nvec++; if (hit_cnt !== 16'h0) begin nerr++; $display("FAIL rst_hits got %h want 0", hit_cnt); end
      nvec++; if (miss_cnt !== 16'h0) begin nerr++; $display("FAIL rst_misses got %h want 0", miss_cnt); end
      nvec++; if (instr !== 32'h0) begin nerr++; $display("FAIL rst_instr got %h want 0", instr); end
   endtask

   task automatic test_cold_miss();
      int n;
      PC = 32'h000; READ = 1'b1; #1;
      nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL cold_busy got %b want 1", busy); end
      nvec++; if (mem_read !== 1'b0) begin nerr++; $display("FAIL cold_memread0 got %b want 0", mem_read); end
      cyc();
      nvec++; if (mem_read !== 1'b1) begin nerr++; $display("FAIL cold_memread got %b want 1", mem_read); end
      nvec++; if (mem_addr !== 6'h00) begin nerr++; $display("FAIL cold_addr got %h want 00", mem_addr); end
      wait_idle(n);
      nvec++; if (n + 1 !== 7) begin nerr++; $display("FAIL cold_penalty got %0d want 7", n + 1); end
      nvec++; if (instr !== 32'h1000_0000) begin nerr++; $display("FAIL cold_instr got %h want 10000000", instr); end
      nvec++; if (miss_cnt !== 16'd1) begin nerr++; $display("FAIL cold_misses got %0d want 1", miss_cnt); end
      nvec++; if (hit_cnt !== 16'd0) begin nerr++; $display("FAIL cold_hits got %0d want 0", hit_cnt); end
   endtask

   task automatic test_spatial_hits();
      cyc();
      for (int i = 1; i <= 3; i++) begin
         PC = 32'(4 * i); #1;
         nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL hit%0d_busy got %b want 0", i, busy); end
         nvec++; if (mem_read !== 1'b0) begin nerr++; $display("FAIL hit%0d_memread got %b want 0", i, mem_read); end
         nvec++; if (instr !== 32'h1000_0000 + 32'(4 * i)) begin
            nerr++; $display("FAIL hit%0d_instr got %h want %h", i, instr, 32'h1000_0000 + 32'(4 * i));
         end
         cyc();
      end
      READ = 1'b0; #1;
      nvec++; if (hit_cnt !== 16'd4) begin nerr++; $display("FAIL hits_count got %0d want 4", hit_cnt); end
      nvec++; if (instr !== 32'h0) begin nerr++; $display("FAIL noread_instr got %h want 0", instr); end
   endtask

   task automatic test_conflict();
      int n;
      PC = 32'h080; READ = 1'b1; #1;
      nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL conf1_busy got %b want 1", busy); end
      cyc();
      nvec++; if (mem_addr !== 6'h08) begin nerr++; $display("FAIL conf1_addr got %h want 08", mem_addr); end
      wait_idle(n);
      nvec++; if (instr !== 32'h1000_0080) begin nerr++; $display("FAIL conf1_instr got %h want 10000080", instr); end
      cyc();
      PC = 32'h000; #1;
      nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL conf2_busy got %b want 1", busy); end
      cyc();
      nvec++; if (mem_addr !== 6'h00) begin nerr++; $display("FAIL conf2_addr got %h want 00", mem_addr); end
      wait_idle(n);
      READ = 1'b0; #1;
      nvec++; if (miss_cnt !== 16'd3) begin nerr++; $display("FAIL conf_misses got %0d want 3", miss_cnt); end
      nvec++; if (hit_cnt !== 16'd5) begin nerr++; $display("FAIL conf_hits got %0d want 5", hit_cnt); end
   endtask

   task automatic test_pc_change_in_miss();
      int n;
      PC = 32'h010; READ = 1'b1;
      cyc();
      PC = 32'h3F0; #1;
      n = 0;
      while (mem_read === 1'b1 && n < 40) begin
         nvec++; if (mem_addr !== 6'h01) begin nerr++; $display("FAIL held_addr c%0d got %h want 01", n, mem_addr); end
         cyc();
         n++;
      end
      nvec++; if (n !== 6) begin nerr++; $display("FAIL held_cycles got %0d want 6", n); end
      nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL remiss_busy got %b want 1", busy); end
      nvec++; if (mem_read !== 1'b0) begin nerr++; $display("FAIL remiss_memread got %b want 0", mem_read); end
      cyc();
      nvec++; if (mem_addr !== 6'h3F) begin nerr++; $display("FAIL remiss_addr got %h want 3f", mem_addr); end
      wait_idle(n);
      nvec++; if (instr !== 32'h1000_03F0) begin nerr++; $display("FAIL remiss_instr got %h want 100003f0", instr); end
      nvec++; if (miss_cnt !== 16'd5) begin nerr++; $display("FAIL remiss_misses got %0d want 5", miss_cnt); end
      cyc();
      PC = 32'h014; #1;
      nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL line1_busy got %b want 0", busy); end
      nvec++; if (instr !== 32'h1000_0014) begin nerr++; $display("FAIL line1_instr got %h want 10000014", instr); end
      READ = 1'b0; #1;
   endtask

   task automatic test_reset_mid_miss();
      int n;
      PC = 32'h020; READ = 1'b1;
      cyc();
      cyc();
      #2;
      RESET = 1'b1; #1;
      nvec++; if (mem_read !== 1'b0) begin nerr++; $display("FAIL arst_memread got %b want 0", mem_read); end
      nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL arst_busy got %b want 0", busy); end
      nvec++; if (hit_cnt !== 16'h0) begin nerr++; $display("FAIL arst_hits got %h want 0", hit_cnt); end
      nvec++; if (miss_cnt !== 16'h0) begin nerr++; $display("FAIL arst_misses got %h want 0", miss_cnt); end
      cyc();
      READ = 1'b0;
      RESET = 1'b0;
      #1;
      PC = 32'h004; READ = 1'b1; #1;
      nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL stale_busy got %b want 1", busy); end
      nvec++; if (instr !== 32'h0) begin nerr++; $display("FAIL stale_instr got %h want 0", instr); end
      cyc();
      nvec++; if (mem_addr !== 6'h00) begin nerr++; $display("FAIL stale_addr got %h want 00", mem_addr); end
      wait_idle(n);
      nvec++; if (instr !== 32'h1000_0004) begin nerr++; $display("FAIL stale_instr2 got %h want 10000004", instr); end
      nvec++; if (miss_cnt !== 16'd1) begin nerr++; $display("FAIL stale_misses got %0d want 1", miss_cnt); end
      READ = 1'b0; #1;
   endtask

   task automatic test_saturation();
      int n;
      do_reset();
      PC = 32'h000; READ = 1'b1;
      wait_idle(n);
      for (int i = 1; i <= 20; i++) begin
         cyc();
         if (i == 15) begin
            nvec++; if (s_hit_cnt !== 4'hF) begin nerr++; $display("FAIL sat15 got %h want f", s_hit_cnt); end
         end
      end
      nvec++; if (s_hit_cnt !== 4'hF) begin nerr++; $display("FAIL sat20 got %h want f", s_hit_cnt); end
      nvec++; if (hit_cnt !== 16'd20) begin nerr++; $display("FAIL wide20 got %0d want 20", hit_cnt); end
      nvec++; if (s_miss_cnt !== 4'd1) begin nerr++; $display("FAIL sat_misses got %0d want 1", s_miss_cnt); end
      READ = 1'b0; #1;
   endtask

   initial begin
      RESET = 1'b0; READ = 1'b0; PC = 32'h0;
      #3;
      test_reset();
      test_cold_miss();
      test_spatial_hits();
      test_conflict();
      test_pc_change_in_miss();
      test_reset_mid_miss();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
